bitonic_merge_pipe: RTL and testbench

- Parametrised, fully pipelined bitonic merger for NUM = 2**LOG_NUM keyed entries, each with a label; one merge network per beat.
- Successor to the fixed 8-input bitonic merge stage; sits after two opposite-direction half-sorters in the sorting network.
- Adds over the fixed merger: per-beat runtime sort direction, valid/ready backpressure with a global stall, and a deterministic tie rule.

---
 rtl/bitonic_merge_pipe_pkg.sv | 20 ++
 rtl/bitonic_merge_pipe_if.sv | 32 +++
 rtl/bitonic_merge_pipe_cas_stage.sv | 53 +++++
 rtl/bitonic_merge_pipe.sv | 85 ++++++++
 tb/tb_bitonic_merge_pipe.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bitonic_merge_pipe_pkg.sv
// Shared definitions for the bitonic merge pipeline: defaults and the
// lane-indexing helpers used by the compare-exchange columns.
package bitonic_merge_pipe_pkg;

    localparam int DEFAULT_LOG_NUM     = 3;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_LABEL_WIDTH = 3;

    // Distance between compare partners in stage s of an NUM-entry merger.
    function automatic int stage_stride(input int num, input int s);
        return num >> (s + 1);
    endfunction

    // A lane owns a compare-exchange when its stride bit is clear; its
    // partner is lane + stride.
    function automatic bit is_low_lane(input int lane, input int stride);
        return (lane & stride) == 0;
    endfunction

endpackage

// File: rtl/bitonic_merge_pipe_if.sv
// Stream bundle for the merger: input beat (x side) and output beat (y side).
interface bitonic_merge_pipe_if #(
    parameter int LOG_NUM     = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3
);
    localparam int NUM = 1 << LOG_NUM;

    logic                         x_valid;
    logic                         x_ready;
    logic                         x_ascending;
    logic [DATA_WIDTH*NUM-1:0]    x;
    logic [LABEL_WIDTH*NUM-1:0]   x_label;
    logic [DATA_WIDTH*NUM-1:0]    y;
    logic [LABEL_WIDTH*NUM-1:0]   y_label;
    logic                         y_ascending;
    logic                         y_valid;
    logic                         y_ready;

    // Environment side: produces input beats, consumes output beats.
    modport master (
        output x_valid, x_ascending, x, x_label, y_ready,
        input  x_ready, y, y_label, y_ascending, y_valid
    );

    // Merger side.
    modport slave (
        input  x_valid, x_ascending, x, x_label, y_ready,
        output x_ready, y, y_label, y_ascending, y_valid
    );

endinterface

// File: rtl/bitonic_merge_pipe_cas_stage.sv
// One combinational compare-exchange column of the bitonic merger.
// Lanes i and i+D are compared; equal keys never swap so the lower lane
// keeps its original entry.
module bitonic_cas_stage
    import bitonic_merge_pipe_pkg::*;
#(
    parameter int NUM         = 8,
    parameter int D           = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3,
    parameter int SIGNED      = 0
) (
    input  logic [DATA_WIDTH*NUM-1:0]  key_in,
    input  logic [LABEL_WIDTH*NUM-1:0] label_in,
    input  logic                       ascending,
    output logic [DATA_WIDTH*NUM-1:0]  key_out,
    output logic [LABEL_WIDTH*NUM-1:0] label_out
);

    for (genvar i = 0; i < NUM; i++) begin : lane
        if (is_low_lane(i, D)) begin : pair
            logic [DATA_WIDTH-1:0]  lo_key;
            logic [DATA_WIDTH-1:0]  hi_key;
            logic [LABEL_WIDTH-1:0] lo_label;
            logic [LABEL_WIDTH-1:0] hi_label;
            logic                   hi_less;
            logic                   lo_less;
            logic                   swap;

            assign lo_key   = key_in[i*DATA_WIDTH +: DATA_WIDTH];
            assign hi_key   = key_in[(i+D)*DATA_WIDTH +: DATA_WIDTH];
            assign lo_label = label_in[i*LABEL_WIDTH +: LABEL_WIDTH];
            assign hi_label = label_in[(i+D)*LABEL_WIDTH +: LABEL_WIDTH];

            if (SIGNED != 0) begin : cmp_signed
                assign hi_less = $signed(hi_key) < $signed(lo_key);
                assign lo_less = $signed(lo_key) < $signed(hi_key);
            end else begin : cmp_unsigned
                assign hi_less = hi_key < lo_key;
                assign lo_less = lo_key < hi_key;
            end

            // Strict comparisons only: ties leave the pair untouched.
            assign swap = ascending ? hi_less : lo_less;

            assign key_out[i*DATA_WIDTH +: DATA_WIDTH]       = swap ? hi_key : lo_key;
            assign key_out[(i+D)*DATA_WIDTH +: DATA_WIDTH]   = swap ? lo_key : hi_key;
            assign label_out[i*LABEL_WIDTH +: LABEL_WIDTH]     = swap ? hi_label : lo_label;
            assign label_out[(i+D)*LABEL_WIDTH +: LABEL_WIDTH] = swap ? lo_label : hi_label;
        end
    end

endmodule

// File: rtl/bitonic_merge_pipe.sv
// Fully pipelined bitonic merger: LOG_NUM registered compare-exchange
// columns with a single global stall. Direction travels with each beat.
module bitonic_merge_pipe
    import bitonic_merge_pipe_pkg::*;
#(
    parameter int LOG_NUM     = DEFAULT_LOG_NUM,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int LABEL_WIDTH = DEFAULT_LABEL_WIDTH,
    parameter int SIGNED      = 0
) (
    input  logic               clk,
    input  logic               rst,
    bitonic_merge_pipe_if.slave bus
);

    localparam int NUM = 1 << LOG_NUM;
    localparam int KW  = DATA_WIDTH * NUM;
    localparam int LW  = LABEL_WIDTH * NUM;

    logic advance;

    for (genvar s = 0; s < LOG_NUM; s++) begin : stage
        logic [KW-1:0] key_in;
        logic [LW-1:0] label_in;
        logic          asc_in;
        logic          valid_in;
        logic [KW-1:0] key_next;
        logic [LW-1:0] label_next;
        logic [KW-1:0] key_r;
        logic [LW-1:0] label_r;
        logic          asc_r;
        logic          valid_r;

        if (s == 0) begin : from_input
            assign key_in   = bus.x;
            assign label_in = bus.x_label;
            assign asc_in   = bus.x_ascending;
            assign valid_in = bus.x_valid;
        end else begin : from_prev
            assign key_in   = stage[s-1].key_r;
            assign label_in = stage[s-1].label_r;
            assign asc_in   = stage[s-1].asc_r;
            assign valid_in = stage[s-1].valid_r;
        end

        bitonic_cas_stage #(
            .NUM         (NUM),
            .D           (stage_stride(NUM, s)),
            .DATA_WIDTH  (DATA_WIDTH),
            .LABEL_WIDTH (LABEL_WIDTH),
            .SIGNED      (SIGNED)
        ) u_cas (
            .key_in    (key_in),
            .label_in  (label_in),
            .ascending (asc_in),
            .key_out   (key_next),
            .label_out (label_next)
        );

        // Stage register: clears on reset, loads the column result when the pipe advances.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                key_r   <= '0;
                label_r <= '0;
                asc_r   <= 1'b0;
                valid_r <= 1'b0;
            end else if (advance) begin
                key_r   <= key_next;
                label_r <= label_next;
                asc_r   <= asc_in;
                valid_r <= valid_in;
            end
        end
    end

    // The whole pipe moves unless a valid output beat is being refused.
    assign advance = bus.y_ready | ~stage[LOG_NUM-1].valid_r;

    assign bus.x_ready     = advance;
    assign bus.y           = stage[LOG_NUM-1].key_r;
    assign bus.y_label     = stage[LOG_NUM-1].label_r;
    assign bus.y_ascending = stage[LOG_NUM-1].asc_r;
    assign bus.y_valid     = stage[LOG_NUM-1].valid_r;

endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Directed bench for bitonic_merge_pipe (NUM=8, 8-bit keys): sorting in both
// directions, signed keys, ties, backpressure and mid-stream reset.
module tb_bitonic_merge_pipe;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    bitonic_merge_pipe_if #(.LOG_NUM(3), .DATA_WIDTH(8), .LABEL_WIDTH(3)) ubus ();
    bitonic_merge_pipe_if #(.LOG_NUM(3), .DATA_WIDTH(8), .LABEL_WIDTH(3)) sbus ();

    bitonic_merge_pipe #(
        .LOG_NUM(3), .DATA_WIDTH(8), .LABEL_WIDTH(3), .SIGNED(0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ubus)
    );

    bitonic_merge_pipe #(
        .LOG_NUM(3), .DATA_WIDTH(8), .LABEL_WIDTH(3), .SIGNED(1)
    ) s_dut (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [23:0] pl(input logic [2:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [63:0] bp_keys(input int n);
        logic [7:0] b;
        b = 8'(10 * n);
        return pk(b, b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd7, b + 8'd6, b + 8'd5, b + 8'd4);
    endfunction

    function automatic logic [63:0] bp_sorted(input int n);
        logic [7:0] b;
        b = 8'(10 * n);
        return pk(b, b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4, b + 8'd5, b + 8'd6, b + 8'd7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [23:0] id_labels;
    logic [23:0] bp_lab;

    initial begin
        int          sent;
        int          got;
        logic        prev_stall;
        logic [63:0] prev_y;
        logic [23:0] prev_l;

        vectors     = 0;
        miscompares = 0;
        id_labels   = pl(0, 1, 2, 3, 4, 5, 6, 7);
        bp_lab      = pl(0, 1, 2, 3, 7, 6, 5, 4);

        rst = 1'b0;
        ubus.x_valid = 1'b0; ubus.x_ascending = 1'b0; ubus.x = '0; ubus.x_label = '0; ubus.y_ready = 1'b1;
        sbus.x_valid = 1'b0; sbus.x_ascending = 1'b0; sbus.x = '0; sbus.x_label = '0; sbus.y_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_output("rst_y_valid", 64'(ubus.y_valid), 64'd0);
        check_output("rst_y", ubus.y, 64'd0);
        check_output("rst_y_label", 64'(ubus.y_label), 64'd0);
        check_output("rst_y_asc", 64'(ubus.y_ascending), 64'd0);
        check_output("rst_x_ready", 64'(ubus.x_ready), 64'd1);

        // Three back-to-back beats: ascending, descending, ties
        tick();
        rst = 1'b1;
        ubus.x_valid = 1'b1; ubus.x_ascending = 1'b1;
        ubus.x = pk(1, 4, 6, 9, 8, 5, 3, 2); ubus.x_label = id_labels;
        sbus.x_valid = 1'b1; sbus.x_ascending = 1'b1;
        sbus.x = pk(8'h80, 8'hFF, 8'h00, 8'h7F, 8'h7E, 8'h01, 8'hFE, 8'h81); sbus.x_label = id_labels;
        tick();
        ubus.x_ascending = 1'b0;
        ubus.x = pk(9, 6, 4, 1, 2, 3, 5, 8); ubus.x_label = id_labels;
        sbus.x_valid = 1'b0;
        tick();
        check_output("latency_early", 64'(ubus.y_valid), 64'd0);
        ubus.x_ascending = 1'b1;
        ubus.x = pk(5, 5, 5, 5, 5, 5, 5, 5); ubus.x_label = id_labels;
        tick();
        ubus.x_valid = 1'b0;
        check_output("asc_valid", 64'(ubus.y_valid), 64'd1);
        check_output("asc_y", ubus.y, pk(1, 2, 3, 4, 5, 6, 8, 9));
        check_output("asc_label", 64'(ubus.y_label), 64'(pl(0, 7, 6, 1, 5, 2, 4, 3)));
        check_output("asc_dir", 64'(ubus.y_ascending), 64'd1);
        check_output("signed_valid", 64'(sbus.y_valid), 64'd1);
        check_output("signed_y", sbus.y, pk(8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h7E, 8'h7F));
        check_output("signed_label", 64'(sbus.y_label), 64'(pl(0, 7, 6, 1, 2, 5, 4, 3)));
        tick();
        check_output("desc_valid", 64'(ubus.y_valid), 64'd1);
        check_output("desc_y", ubus.y, pk(9, 8, 6, 5, 4, 3, 2, 1));
        check_output("desc_label", 64'(ubus.y_label), 64'(pl(0, 7, 1, 6, 2, 5, 4, 3)));
        check_output("desc_dir", 64'(ubus.y_ascending), 64'd0);
        check_output("signed_bubble", 64'(sbus.y_valid), 64'd0);
        tick();
        check_output("tie_valid", 64'(ubus.y_valid), 64'd1);
        check_output("tie_y", ubus.y, pk(5, 5, 5, 5, 5, 5, 5, 5));
        check_output("tie_label", 64'(ubus.y_label), 64'(id_labels));
        tick();
        check_output("drain_valid", 64'(ubus.y_valid), 64'd0);

        // Backpressure: ten beats, y_ready pattern 1,0,0,1
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_y     = '0;
        prev_l     = '0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            @(posedge clk);
            #1;
            if (prev_stall) begin
                check_output("hold_valid", 64'(ubus.y_valid), 64'd1);
                check_output("hold_y", ubus.y, prev_y);
                check_output("hold_label", 64'(ubus.y_label), 64'(prev_l));
            end
            ubus.y_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (sent < 10) begin
                ubus.x_valid = 1'b1; ubus.x_ascending = 1'b1;
                ubus.x = bp_keys(sent); ubus.x_label = id_labels;
            end else begin
                ubus.x_valid = 1'b0;
            end
            #1;
            check_output("bp_x_ready", 64'(ubus.x_ready), 64'(!(ubus.y_valid && !ubus.y_ready)));
            if (ubus.y_valid && ubus.y_ready) begin
                check_output("bp_y", ubus.y, bp_sorted(got));
                check_output("bp_label", 64'(ubus.y_label), 64'(bp_lab));
                got++;
            end
            prev_stall = ubus.y_valid && !ubus.y_ready;
            prev_y     = ubus.y;
            prev_l     = ubus.y_label;
            if (ubus.x_valid && ubus.x_ready) sent++;
        end
        check_output("bp_count", 64'(got), 64'd10);
        ubus.x_valid = 1'b0;
        ubus.y_ready = 1'b1;
        repeat (4) tick();
        check_output("bp_drained", 64'(ubus.y_valid), 64'd0);

        // Reset with beats in flight
        ubus.x_valid = 1'b1; ubus.x_ascending = 1'b1; ubus.x_label = id_labels;
        ubus.x = bp_keys(1);
        tick();
        ubus.x = bp_keys(2);
        tick();
        ubus.x = bp_keys(3);
        tick();
        check_output("pre_reset_valid", 64'(ubus.y_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("mid_rst_valid", 64'(ubus.y_valid), 64'd0);
        check_output("mid_rst_y", ubus.y, 64'd0);
        check_output("mid_rst_label", 64'(ubus.y_label), 64'd0);
        check_output("mid_rst_x_ready", 64'(ubus.x_ready), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        ubus.x_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("post_rst_empty", 64'(ubus.y_valid), 64'd0);
        end
        ubus.x_valid = 1'b1;
        ubus.x = bp_keys(5);
        tick();
        ubus.x_valid = 1'b0;
        tick();
        check_output("post_rst_early", 64'(ubus.y_valid), 64'd0);
        tick();
        check_output("post_rst_valid", 64'(ubus.y_valid), 64'd1);
        check_output("post_rst_y", ubus.y, bp_sorted(5));
        check_output("post_rst_label", 64'(ubus.y_label), 64'(bp_lab));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
